telemetry_tx: RTL

// - FPGA->host reporting path. Frames status and phase/calibration readback into the proto245a TX FIFO byte stream.
// - Sits beside receiver on clk; receiver (or a debug trigger) issues requests.
// - Host decodes frames by resyncing on SYNC_BYTE.

---
 rtl/telemetry_tx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/telemetry_tx.sv
// telemetry_tx: frames status words and phase/calibration dumps into the TX FIFO byte stream.
// Frame layout: SYNC_BYTE, TYPE, LEN_LO, LEN_HI, payload[LEN], CHK.
// Optional feature macro: TELEMETRY_TX_CRC8_EN selects a CRC-8 (poly 0x07, init 0, MSB-first)
// for CHK instead of the default 8-bit modular sum.
module telemetry_tx #(
  parameter int unsigned NUM_CHANNELS   = 128,
  parameter int unsigned CLK_CNT_W      = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TX_FIFO_LOAD_W = 10,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  localparam int unsigned AW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_type,
  input  logic [31:0]               status_word,
  output logic [AW-1:0]             ch_addr,
  input  logic [CLK_CNT_W-1:0]      phase_rdata,
  input  logic [CLK_CNT_W-1:0]      calib_rdata,
  input  logic                      txfifo_full,
  input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
  output logic [DATA_W-1:0]         txfifo_data,
  output logic                      txfifo_wr,
  output logic                      busy,
  output logic [15:0]               frames_sent
);

  typedef enum logic [2:0] {
    StIdle, StSync, StType, StLen0, StLen1, StPayload, StChk
  } state_e;

  state_e      r_state, w_state_d;
  logic [1:0]  r_type, w_type_d;
  logic [31:0] r_status, w_status_d;
  logic [15:0] r_idx, w_idx_d;
  logic [7:0]  r_chk, w_chk_d;
  logic [15:0] r_frames, w_frames_d;
  logic [1:0]  r_rst_sync;

  logic [15:0] w_len;
  logic [7:0]  w_byte;
  logic [7:0]  w_payload;
  logic        w_wr;

  // FIFO occupancy is informational only; full alone governs flow.
  logic w_unused_load;
  assign w_unused_load = ^txfifo_load;

  // Fold one emitted byte into the running check value.
  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef TELEMETRY_TX_CRC8_EN
    logic [7:0] x;
    x = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    end
    return x;
`else
    return acc + b;
`endif
  endfunction

  // Reset release is synchronised so the FSM never leaves IDLE on a metastable edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  // Frame state, latched request, payload index, running check and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_type   <= 2'd0;
      r_status <= 32'd0;
      r_idx    <= 16'd0;
      r_chk    <= 8'd0;
      r_frames <= 16'd0;
    end else begin
      r_state  <= w_state_d;
      r_type   <= w_type_d;
      r_status <= w_status_d;
      r_idx    <= w_idx_d;
      r_chk    <= w_chk_d;
      r_frames <= w_frames_d;
    end
  end

  // Payload length from the latched type; reserved carries no payload.
  always_comb begin
    unique case (r_type)
      2'd0:    w_len = 16'd4;
      2'd1:    w_len = 16'(NUM_CHANNELS);
      2'd2:    w_len = 16'(NUM_CHANNELS);
      default: w_len = 16'd0;
    endcase
  end

  // Current payload byte: little-endian status or zero-extended readback at ch_addr.
  always_comb begin
    w_payload = 8'd0;
    unique case (r_type)
      2'd0:    w_payload = r_status[{r_idx[1:0], 3'b000} +: 8];
      2'd1:    w_payload = 8'(phase_rdata);
      2'd2:    w_payload = 8'(calib_rdata);
      default: w_payload = 8'd0;
    endcase
  end

  // Next-state and byte emission; every byte-emitting state stalls while the FIFO is full.
  always_comb begin
    w_state_d  = r_state;
    w_type_d   = r_type;
    w_status_d = r_status;
    w_idx_d    = r_idx;
    w_chk_d    = r_chk;
    w_frames_d = r_frames;
    w_byte     = 8'd0;
    w_wr       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (req_valid && r_rst_sync[1]) begin
          w_type_d   = req_type;
          w_status_d = status_word;
          w_idx_d    = 16'd0;
          w_chk_d    = 8'd0;
          w_state_d  = StSync;
        end
      end
      StSync: begin
        w_byte = SYNC_BYTE;
        if (!txfifo_full) begin
          w_wr      = 1'b1;
          w_state_d = StType;
        end
      end
      StType: begin
        w_byte = {6'b0, r_type};
        if (!txfifo_full) begin
          w_wr      = 1'b1;
          w_chk_d   = chk_step(r_chk, w_byte);
          w_state_d = StLen0;
        end
      end
      StLen0: begin
        w_byte = w_len[7:0];
        if (!txfifo_full) begin
          w_wr      = 1'b1;
          w_chk_d   = chk_step(r_chk, w_byte);
          w_state_d = StLen1;
        end
      end
      StLen1: begin
        w_byte = w_len[15:8];
        if (!txfifo_full) begin
          w_wr      = 1'b1;
          w_chk_d   = chk_step(r_chk, w_byte);
          w_idx_d   = 16'd0;
          w_state_d = (w_len == 16'd0) ? StChk : StPayload;
        end
      end
      StPayload: begin
        w_byte = w_payload;
        if (!txfifo_full) begin
          w_wr    = 1'b1;
          w_chk_d = chk_step(r_chk, w_byte);
          if (r_idx == w_len - 16'd1) begin
            w_idx_d   = 16'd0;
            w_state_d = StChk;
          end else begin
            w_idx_d = r_idx + 16'd1;
          end
        end
      end
      StChk: begin
        w_byte = r_chk;
        if (!txfifo_full) begin
          w_wr       = 1'b1;
          w_frames_d = r_frames + 16'd1;
          w_state_d  = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs derive from registered state, so async reset forces them idle immediately.
  always_comb begin
    txfifo_wr   = w_wr;
    txfifo_data = DATA_W'(w_byte);
    busy        = (r_state != StIdle);
    req_ready   = (r_state == StIdle) && r_rst_sync[1];
    ch_addr     = (r_state == StPayload) ? r_idx[AW-1:0] : '0;
    frames_sent = r_frames;
  end

endmodule
